// File: rtl/decoder24_strobe_if.sv
// Code handshake between a code source and the strobe decoder.
interface decoder24_strobe_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] code;

  modport master (output in_valid, output code, input in_ready);
  modport slave  (input in_valid, input code, output in_ready);
endinterface

// File: rtl/decoder24_strobe.sv
// Sequenced 2-to-4 decoder: buffers 2-bit codes in a FIFO and replays each
// as a registered one-hot strobe with programmable hold and gap lengths.
module decoder24_strobe #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  decoder24_strobe_if.slave        in_bus,
  input  logic                     en,
  input  logic [CW-1:0]            hold_len,
  input  logic [CW-1:0]            gap_len,
  output logic [3:0]               y,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      y_d;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [1:0]      head;
  logic            push, pop;

  assign in_bus.in_ready = !rst && (count != (AW+1)'(DEPTH));
  assign push            = in_bus.in_valid && in_bus.in_ready;
  assign head            = mem[rd_ptr];
  assign busy            = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        y_d = '0;
        if (en && count != '0) begin
          pop     = 1'b1;
          y_d     = 4'b0001 << head;
          cnt_d   = (hold_len == '0) ? '0 : hold_len - CW'(1);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          y_d = '0;
          if (gap_len == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = gap_len - CW'(1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        y_d = '0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        y_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y       <= y_d;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_bus.code;
  end

endmodule

// File: tb/tb_decoder24_strobe.sv
// Randomized and directed bench for decoder24_strobe against a
// timestamp-based reference model of the strobe schedule.
module tb_decoder24_strobe;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] hold_len;
  logic [CW-1:0] gap_len;
  logic [3:0]    y;
  logic          busy;
  logic [2:0]    count;

  always #5 clk = ~clk;

  decoder24_strobe_if bus ();

  decoder24_strobe #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bus   (bus),
    .en       (en),
    .hold_len (hold_len),
    .gap_len  (gap_len),
    .y        (y),
    .busy     (busy),
    .count    (count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO as a queue, strobe schedule as edge timestamps.
  int       q[$];
  int       edge_no   = 0;
  int       drive_end = -1;
  int       idle_edge = -1;
  int       free_edge = 0;
  logic [3:0] m_y     = '0;
  logic     m_busy    = 1'b0;
  bit       acc;
  logic [3:0] ylog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
    end
  endtask

  task automatic step();
    bit rs, es, vs, rdy;
    int cs, hs, gs, h, c;
    rs  = rst;
    es  = en;
    vs  = bus.in_valid;
    cs  = int'(bus.code);
    hs  = int'(hold_len);
    gs  = int'(gap_len);
    rdy = !rs && (q.size() != DEPTH);
    @(posedge clk);
    #1;
    edge_no++;
    acc = vs && rdy;
    if (rs) begin
      q.delete();
      m_y       = '0;
      m_busy    = 1'b0;
      drive_end = -1;
      idle_edge = -1;
      free_edge = edge_no + 1;
    end else begin
      if (edge_no == drive_end) begin
        m_y       = '0;
        idle_edge = edge_no + gs;
        free_edge = idle_edge + 1;
        if (gs == 0) m_busy = 1'b0;
      end else if (m_busy && edge_no == idle_edge) begin
        m_busy = 1'b0;
      end
      if (edge_no >= free_edge && es && q.size() > 0) begin
        h         = (hs == 0) ? 1 : hs;
        c         = q.pop_front();
        m_y       = 4'(1 << c);
        m_busy    = 1'b1;
        drive_end = edge_no + h;
        idle_edge = -1;
        free_edge = 32'h7fff_ffff;
      end
      if (vs && rdy) q.push_back(cs);
    end
    ylog.push_back(y);
    check("y", 32'(y), 32'(m_y));
    check("busy", 32'(busy), 32'(m_busy));
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(bus.in_ready), 32'(!rst && q.size() != DEPTH));
    check("onehot", 32'($countones(y) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_code(input logic [1:0] c);
    bus.in_valid = 1'b1;
    bus.code     = c;
    for (int i = 0; i < 60; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  function automatic void strobe_starts(output int s[$]);
    logic [3:0] prev;
    prev = '0;
    s.delete();
    foreach (ylog[i]) begin
      if (ylog[i] != '0 && (prev == '0 || ylog[i] != prev)) s.push_back(int'(ylog[i]));
      prev = ylog[i];
    end
  endfunction

  initial begin
    int s[$];
    int exp_seq[$];
    int first;
    logic [3:0] ord_exp [14];
    ord_exp = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0,
                4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};

    rst = 1'b1; en = 1'b0; hold_len = '0; gap_len = '0;
    bus.in_valid = 1'b0; bus.code = '0;
    run(2);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    run(1);

    // Basic decode
    en = 1'b1; hold_len = 8'd3; gap_len = 8'd0;
    push_code(2'd2);
    check("basic_y_accept", 32'(y), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("basic_y", 32'(y), 32'h4);
      check("basic_busy", 32'(busy), 32'd1);
    end
    step();
    check("basic_y_end", 32'(y), 32'd0);
    check("basic_busy_end", 32'(busy), 32'd0);
    check("basic_count_end", 32'(count), 32'd0);
    run(2);

    // Ordering and period
    hold_len = 8'd1; gap_len = 8'd2;
    ylog.delete();
    for (int c = 0; c < 4; c++) push_code(2'(c));
    run(16);
    first = -1;
    foreach (ylog[i]) if (first < 0 && ylog[i] != '0) first = i;
    if (first < 0 || first + 14 > ylog.size()) begin
      check("order_found", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 14; i++) check("order_seq", 32'(ylog[first+i]), 32'(ord_exp[i]));
    end

    // Full / backpressure
    en = 1'b0; hold_len = 8'd1; gap_len = 8'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.code = 2'(i);
      for (int k = 0; k < 10; k++) begin
        step();
        if (acc) break;
      end
    end
    bus.code = 2'd1;
    run(3);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    ylog.delete();
    en = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step();
    check("fifth_accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    run(30);
    strobe_starts(s);
    exp_seq = '{1, 2, 4, 8, 2};
    check("full_nstrobes", 32'(s.size()), 32'd5);
    foreach (exp_seq[i]) if (i < s.size()) check("full_order", 32'(s[i]), 32'(exp_seq[i]));

    // Zero hold
    hold_len = 8'd0; gap_len = 8'd0;
    ylog.delete();
    push_code(2'd3);
    run(4);
    first = 0;
    foreach (ylog[i]) if (ylog[i] == 4'h8) first++;
    check("zero_hold_len", 32'(first), 32'd1);

    // Enable dropped during a strobe
    hold_len = 8'd5;
    push_code(2'd1);
    push_code(2'd2);
    en = 1'b0;
    run(12);
    check("en_low_count", 32'(count), 32'd1);
    check("en_low_busy", 32'(busy), 32'd0);
    en = 1'b1;
    run(8);

    // Reset during DRIVE with codes queued
    hold_len = 8'd4; gap_len = 8'd1;
    push_code(2'd0);
    push_code(2'd1);
    push_code(2'd2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_y", 32'(y), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    ylog.delete();
    run(10);
    first = 0;
    foreach (ylog[i]) if (ylog[i] != '0) first++;
    check("no_stale_strobe", 32'(first), 32'd0);

    // Simultaneous push and pop
    hold_len = 8'd2; gap_len = 8'd1;
    en = 1'b0;
    push_code(2'd1);
    ylog.delete();
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.code = 2'd3;
    step();
    check("pushpop_count", 32'(count), 32'd1);
    bus.in_valid = 1'b0;
    run(12);
    strobe_starts(s);
    check("pushpop_n", 32'(s.size()), 32'd2);
    if (s.size() == 2) begin
      check("pushpop_first", 32'(s[0]), 32'h2);
      check("pushpop_second", 32'(s[1]), 32'h8);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      en           = ($urandom_range(0, 9) < 8);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.code     = 2'($urandom_range(0, 3));
      hold_len     = CW'($urandom_range(0, 3));
      gap_len      = CW'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; en = 1'b1; bus.in_valid = 1'b0;
    run(40);
    check("drain_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder24_strobe.md
# decoder24_strobe

Sequenced 2-to-4 decoder, the receive-side counterpart of the 4-to-2 encoder. It accepts 2-bit codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a registered one-hot strobe on `y[3:0]` with a programmable hold and gap. It sits between a code source (encoder output, a register interface or a controller) and one-hot select/strobe lines.

## Interface
- `DEPTH`, default 4: FIFO entries; a power of 2, at least 2.
- `CW`, default 8: width of the hold/gap length fields.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `code` is valid.
- `in_ready` out 1: FIFO can accept a code.
- `code` in 2: code to decode (0..3).
- `en` in 1: gates the start of a new strobe.
- `hold_len` in CW: strobe width in cycles; 0 is treated as 1.
- `gap_len` in CW: extra idle cycles after each strobe; 0 is allowed.
- `y` out 4: registered one-hot strobe, `y = 4'b0001 << code`.
- `busy` out 1: FSM is not in IDLE.
- `count` out log2(DEPTH)+1: FIFO occupancy.

## Operation
- Reset (`rst` high at an edge):
  - FIFO is emptied; `count`=0, `y`=0, `busy`=0, FSM goes to IDLE, counters are cleared.
  - `in_ready`=0 while `rst` is high.
  - Reset mid-strobe aborts immediately: `y`=0 after that edge, and queued codes are discarded.
- FIFO:
  - A push occurs on an edge where `in_valid && in_ready`.
  - `in_ready = !rst && (count != DEPTH)`.
  - When the FIFO is full, `in_ready` is low even if a pop occurs in the same cycle. No overflow path exists.
  - A simultaneous push and pop when not full leaves `count` unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - Codes are replayed in FIFO order.
- FSM states are IDLE, DRIVE and GAP.
  - IDLE: if `en && count != 0`, pop the head, set `y <= 1 << head`, load `cnt <= max(hold_len,1)-1`, go to DRIVE. Otherwise `y` stays 0.
  - DRIVE: `y` holds. If `cnt != 0`, `cnt <= cnt-1`. If `cnt == 0`:
    - `y <= 0`.
    - If `gap_len == 0`, go to IDLE.
    - Otherwise load `cnt <= gap_len-1` and go to GAP.
  - GAP: `y` = 0. Decrement `cnt`; at `cnt == 0`, go to IDLE.
- `hold_len` is sampled only in IDLE at pop. `gap_len` is sampled only at DRIVE exit. Changes mid-strobe have no effect on the current strobe.
- `en` low only blocks starts from IDLE. A strobe or gap already in progress runs to completion.
- `code` has no invalid values; all 4 map to exactly one asserted `y` bit.
- `y` is always either 0 or exactly one-hot.

## Timing
- Latency:
  - A code accepted at edge N into an empty FIFO with FSM in IDLE and `en`=1 pops at edge N+1.
  - `y` is asserted from edge N+1 for exactly `max(hold_len,1)` cycles.
- Strobe period: `max(hold_len,1) + gap_len + 1` cycles. The +1 is the IDLE cycle, so consecutive strobes are always separated by at least one `y`=0 cycle.
- `count` and `busy` are registered and update at the same edge as the push/pop or state change.
- `in_ready` is combinational from `count` and `rst` only, with no dependence on `in_valid`.
- Full throughput is one code per period. The source stalls via `in_ready` once DEPTH codes are pending.

## Test plan
- Basic decode:
  - Stimulus: after reset, push `code`=2, `hold_len`=3, `gap_len`=0, `en`=1.
  - Required: `y`=4'b0100 for 3 cycles starting one cycle after the accepting edge, then 0; `busy` high for the same 3 cycles; `count` returns to 0.
- Ordering/period:
  - Stimulus: push codes 0,1,2,3 back-to-back with `hold_len`=1, `gap_len`=2.
  - Required: `y` sequence is 0001,0,0,0, 0010,0,0,0, 0100,0,0,0, 1000, then 0; period 4.
- Full/backpressure:
  - Stimulus: `en`=0, hold `in_valid`=1 with codes 0,1,2,3,1.
  - Required: `count` reaches 4; `in_ready`=0 after the 4th accept; 5th code held.
  - Stimulus continued: raise `en`.
  - Required: first pop re-raises `in_ready` and the 5th code is accepted; output order is 0,1,2,3,1.
- Enable/zero-hold:
  - Stimulus: `hold_len`=0 with code 3.
  - Required: `y`=1000 for exactly 1 cycle.
  - Stimulus: drop `en` during a `hold_len`=5 strobe.
  - Required: strobe lasts the full 5 cycles; the next queued code does not start until `en`=1.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle during DRIVE with 2 codes queued.
  - Required: next cycle `y`=0, `count`=0, `busy`=0, `in_ready`=0 during `rst` and 1 after; no stale strobe afterwards.
- Simultaneous push/pop:
  - Stimulus: `count`=1, push on the same edge IDLE pops.
  - Required: `count` stays 1; the newly pushed code is driven after the current strobe and gap.
